// File: rtl/dsss_tx_sequencer_if.sv
// Byte-stream handshake into the DSSS transmit sequencer.
// The master offers payload bytes; the sequencer (slave) answers with s_ready.
interface dsss_tx_sequencer_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/dsss_tx_sequencer.sv
// DSSS frame sequencer: preamble/payload/tail framing, 31-chip m-sequence spreading, BPSK phase to the DDS.
// Optional differential encoding of payload bits when DSSS_DIFF_ENC_EN is defined.
module dsss_tx_sequencer #(
   parameter int unsigned CHIP_DIV  = 100,
   parameter int unsigned PRE_BITS  = 16,
   parameter int unsigned TAIL_BITS = 4,
   parameter logic [4:0]  PN_SEED   = 5'b00001
) (
   input  logic                 clk_100,
   input  logic                 rst,
   dsss_tx_sequencer_if.slave   s_if,
   output logic                 chip_out,
   output logic [15:0]          dds_phase,
   output logic                 chip_stb,
   output logic                 bit_stb,
   output logic                 tx_active,
   output logic                 err_underrun
);

   localparam int unsigned CW        = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
   localparam logic [CW-1:0] CHIP_LAST = CW'(CHIP_DIV - 1);
   localparam logic [15:0]   PRE_LAST  = 16'(PRE_BITS - 1);
   localparam logic [15:0]   TAIL_LAST = 16'(TAIL_BITS - 1);
   localparam logic [4:0]    IDX_LAST  = 5'd30;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_TAIL     = 2'd3
   } state_e;

   function automatic logic [4:0] lfsr_step(input logic [4:0] v);
      return {v[3:0], v[4] ^ v[2]};
   endfunction

   state_e          state_q, state_d;
   logic [CW-1:0]   chip_cnt_q, chip_cnt_d;
   logic [4:0]      chip_idx_q, chip_idx_d;
   logic [15:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            last_q, last_d;
   logic [4:0]      lfsr_q, lfsr_d;
   logic            chip_stb_q, chip_stb_d;
   logic            bit_stb_q, bit_stb_d;
   logic            chip_out_q, chip_out_d;
   logic [15:0]     dds_q, dds_d;
   logic            tx_active_q, tx_active_d;
   logic            underrun_q, underrun_d;
   logic            s_ready_s, accept_s, cur_bit_s, payload_bit_s;

`ifdef DSSS_DIFF_ENC_EN
   logic            diff_q, diff_d;
   assign payload_bit_s = shreg_q[7] ^ diff_q;
`else
   assign payload_bit_s = shreg_q[7];
`endif

   // Strobes are registered from next-state counters, so they equal a decode of the live counters.
   always_comb begin
      state_d     = state_q;
      chip_cnt_d  = chip_cnt_q;
      chip_idx_d  = chip_idx_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      last_d      = last_q;
      lfsr_d      = lfsr_q;
      underrun_d  = 1'b0;
      s_ready_s   = 1'b0;
      cur_bit_s   = 1'b0;
`ifdef DSSS_DIFF_ENC_EN
      diff_d      = diff_q;
`endif

      case (state_q)
         ST_IDLE: begin
            s_ready_s = 1'b1;
            cur_bit_s = 1'b0;
         end
         ST_PREAMBLE: begin
            cur_bit_s = ~bit_cnt_q[0];
         end
         ST_PAYLOAD: begin
            cur_bit_s = payload_bit_s;
            s_ready_s = bit_stb_q && (bit_cnt_q == 16'd7) && !last_q;
         end
         ST_TAIL: begin
            cur_bit_s = 1'b0;
         end
         default: begin
            cur_bit_s = 1'b0;
         end
      endcase
      accept_s = s_if.s_valid && s_ready_s;

      if (state_q == ST_IDLE) begin
         if (accept_s) begin
            state_d    = ST_PREAMBLE;
            shreg_d    = s_if.s_data;
            last_d     = s_if.s_last;
            lfsr_d     = PN_SEED;
            chip_cnt_d = {CW{1'b0}};
            chip_idx_d = 5'd0;
            bit_cnt_d  = 16'd0;
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         chip_cnt_d = chip_stb_q ? {CW{1'b0}} : (chip_cnt_q + CW'(1));
         if (bit_stb_q) begin
            chip_idx_d = 5'd0;
            lfsr_d     = PN_SEED;
         end else if (chip_stb_q) begin
            chip_idx_d = chip_idx_q + 5'd1;
            lfsr_d     = lfsr_step(lfsr_q);
         end else begin
            chip_idx_d = chip_idx_q;
         end

         if (bit_stb_q) begin
            bit_cnt_d = bit_cnt_q + 16'd1;
            case (state_q)
               ST_PREAMBLE: begin
                  if (bit_cnt_q == PRE_LAST) begin
                     state_d   = ST_PAYLOAD;
                     bit_cnt_d = 16'd0;
`ifdef DSSS_DIFF_ENC_EN
                     diff_d    = 1'b0;
`endif
                  end else begin
                     state_d = ST_PREAMBLE;
                  end
               end
               ST_PAYLOAD: begin
                  shreg_d = {shreg_q[6:0], 1'b0};
`ifdef DSSS_DIFF_ENC_EN
                  diff_d  = cur_bit_s;
`endif
                  if (bit_cnt_q == 16'd7) begin
                     bit_cnt_d = 16'd0;
                     if (accept_s) begin
                        shreg_d = s_if.s_data;
                        last_d  = s_if.s_last;
                     end else begin
                        state_d    = ST_TAIL;
                        underrun_d = ~last_q;
                     end
                  end else begin
                     state_d = ST_PAYLOAD;
                  end
               end
               ST_TAIL: begin
                  if (bit_cnt_q == TAIL_LAST) begin
                     state_d   = ST_IDLE;
                     bit_cnt_d = 16'd0;
                  end else begin
                     state_d = ST_TAIL;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end else begin
            bit_cnt_d = bit_cnt_q;
         end
      end

      chip_stb_d  = (state_d != ST_IDLE) && (chip_cnt_d == CHIP_LAST);
      bit_stb_d   = chip_stb_d && (chip_idx_d == IDX_LAST);
      chip_out_d  = (state_q != ST_IDLE) && (cur_bit_s ^ lfsr_q[4]);
      dds_d       = chip_out_d ? 16'h8000 : 16'h0000;
      tx_active_d = (state_q != ST_IDLE);
   end

   // State, counters and output registers with synchronous reset.
   always_ff @(posedge clk_100) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         chip_cnt_q  <= {CW{1'b0}};
         chip_idx_q  <= 5'd0;
         bit_cnt_q   <= 16'd0;
         shreg_q     <= 8'h00;
         last_q      <= 1'b0;
         lfsr_q      <= 5'b00000;
         chip_stb_q  <= 1'b0;
         bit_stb_q   <= 1'b0;
         chip_out_q  <= 1'b0;
         dds_q       <= 16'h0000;
         tx_active_q <= 1'b0;
         underrun_q  <= 1'b0;
`ifdef DSSS_DIFF_ENC_EN
         diff_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         chip_cnt_q  <= chip_cnt_d;
         chip_idx_q  <= chip_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         last_q      <= last_d;
         lfsr_q      <= lfsr_d;
         chip_stb_q  <= chip_stb_d;
         bit_stb_q   <= bit_stb_d;
         chip_out_q  <= chip_out_d;
         dds_q       <= dds_d;
         tx_active_q <= tx_active_d;
         underrun_q  <= underrun_d;
`ifdef DSSS_DIFF_ENC_EN
         diff_q      <= diff_d;
`endif
      end
   end

   assign s_if.s_ready = s_ready_s;
   assign chip_out     = chip_out_q;
   assign dds_phase    = dds_q;
   assign chip_stb     = chip_stb_q;
   assign bit_stb      = bit_stb_q;
   assign tx_active    = tx_active_q;
   assign err_underrun = underrun_q;

endmodule

// File: tb/tb_dsss_tx_sequencer.sv
// Scoreboard bench for dsss_tx_sequencer: expected chips and frame summaries are queued at stimulus time
// and popped by a monitor on chip_stb and on the end of each frame.
module tb_dsss_tx_sequencer;
   localparam int CHIP_DIV  = 4;
   localparam int PRE_BITS  = 16;
   localparam int TAIL_BITS = 4;
   localparam int WAIT_LIM  = 40 * 31 * CHIP_DIV;

   typedef struct {
      int cycles;
      int bits;
      int und;
      int rdy;
   } frame_t;

   logic        clk_100 = 1'b0;
   logic        rst;
   logic        chip_out;
   logic [15:0] dds_phase;
   logic        chip_stb, bit_stb, tx_active, err_underrun;

   dsss_tx_sequencer_if s_if ();

   dsss_tx_sequencer #(
      .CHIP_DIV (CHIP_DIV),
      .PRE_BITS (PRE_BITS),
      .TAIL_BITS(TAIL_BITS),
      .PN_SEED  (5'b00001)
   ) dut (
      .clk_100     (clk_100),
      .rst         (rst),
      .s_if        (s_if.slave),
      .chip_out    (chip_out),
      .dds_phase   (dds_phase),
      .chip_stb    (chip_stb),
      .bit_stb     (bit_stb),
      .tx_active   (tx_active),
      .err_underrun(err_underrun)
   );

   always #5 clk_100 = ~clk_100;

   int     n_checks = 0;
   int     n_fail   = 0;
   bit     pn[31];
   bit     exp_chips[$];
   frame_t exp_frames[$];
   bit     abort_flag = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void build_pn();
      logic [4:0] l;
      l = 5'b00001;
      for (int c = 0; c < 31; c++) begin
         pn[c] = l[4];
         l = {l[3:0], l[4] ^ l[2]};
      end
   endfunction

   // Monitor: chip scoreboard, chip_stb period and per-frame statistics.
   initial begin : monitor
      int cyc, last_cyc, f_cyc, f_bits, f_und, f_rdy;
      bit stb_valid, prev_act, e;
      frame_t fr;
      cyc = 0; last_cyc = 0; stb_valid = 1'b0; prev_act = 1'b0;
      f_cyc = 0; f_bits = 0; f_und = 0; f_rdy = 0;
      forever begin
         @(negedge clk_100);
         cyc++;
         if (chip_stb) begin
            if (exp_chips.size() == 0) begin
               check("chip_unexpected", 32'(chip_stb), 32'd0);
            end else begin
               e = exp_chips.pop_front();
               check("chip_out", 32'(chip_out), 32'(e));
               check("dds_phase", 32'(dds_phase), e ? 32'h8000 : 32'h0000);
            end
            if (stb_valid) check("chip_stb_period", 32'(cyc - last_cyc), 32'(CHIP_DIV));
            last_cyc  = cyc;
            stb_valid = 1'b1;
         end
         if (!tx_active) stb_valid = 1'b0;
         if (tx_active && !prev_act) begin
            f_cyc = 0; f_bits = 0; f_und = 0; f_rdy = 0;
         end
         if (tx_active) begin
            f_cyc++;
            if (bit_stb) f_bits++;
            if (err_underrun) f_und++;
            if (s_if.s_ready) f_rdy++;
         end
         if (!tx_active && prev_act) begin
            if (abort_flag) begin
               abort_flag = 1'b0;
            end else if (exp_frames.size() == 0) begin
               check("frame_unexpected", 32'(prev_act), 32'd0);
            end else begin
               fr = exp_frames.pop_front();
               check("frame_cycles", 32'(f_cyc), 32'(fr.cycles));
               check("frame_bit_stb", 32'(f_bits), 32'(fr.bits));
               check("frame_underrun", 32'(f_und), 32'(fr.und));
               check("frame_ready_windows", 32'(f_rdy), 32'(fr.rdy));
            end
         end
         prev_act = tx_active;
      end
   end

   task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input int nbytes,
                             input bit starve, input bit abort);
      bit         bits[$];
      logic [7:0] cur;
      frame_t     fr;
      int         w, nstb;
      bit         first_chip;
`ifdef DSSS_DIFF_ENC_EN
      bit         d;
      d = 1'b0;
`endif
      for (int i = 0; i < PRE_BITS; i++) bits.push_back((i % 2) == 0);
      for (int k = 0; k < nbytes; k++) begin
         cur = (k == 0) ? d0 : d1;
         for (int b = 7; b >= 0; b--) begin
`ifdef DSSS_DIFF_ENC_EN
            d = cur[b] ^ d;
            bits.push_back(d);
`else
            bits.push_back(cur[b]);
`endif
         end
      end
      for (int i = 0; i < TAIL_BITS; i++) bits.push_back(1'b0);
      for (int i = 0; i < bits.size(); i++)
         for (int c = 0; c < 31; c++) exp_chips.push_back(bits[i] ^ pn[c]);
      first_chip = bits[0] ^ pn[0];
      if (!abort) begin
         fr.cycles = bits.size() * 31 * CHIP_DIV;
         fr.bits   = bits.size();
         fr.und    = int'(starve);
         fr.rdy    = nbytes + int'(starve);
         exp_frames.push_back(fr);
      end

      @(negedge clk_100);
      for (int k = 0; k < nbytes; k++) begin
         s_if.s_valid = 1'b1;
         s_if.s_data  = (k == 0) ? d0 : d1;
         s_if.s_last  = (k == nbytes - 1) && !starve;
         w = 0;
         while (!s_if.s_ready && w < WAIT_LIM) begin
            @(negedge clk_100);
            w++;
         end
         check("accept_timeout", 32'(s_if.s_ready), 32'd1);
         if (k > 0) check("accept_in_bit_stb", 32'(bit_stb), 32'd1);
         @(posedge clk_100);
         @(negedge clk_100);
         s_if.s_valid = 1'b0;
         s_if.s_last  = 1'b0;
         if (k == 0) begin
            check("tx_active_at_accept", 32'(tx_active), 32'd0);
            @(negedge clk_100);
            check("tx_active_first_chip", 32'(tx_active), 32'd1);
            check("first_chip", 32'(chip_out), 32'(first_chip));
         end
      end

      if (abort) begin
         nstb = 0; w = 0;
         while (nstb < PRE_BITS + 3 && w < WAIT_LIM) begin
            @(negedge clk_100);
            if (bit_stb) nstb++;
            w++;
         end
         check("abort_reach_payload", 32'(nstb), 32'(PRE_BITS + 3));
         abort_flag = 1'b1;
         rst = 1'b1;
         @(posedge clk_100);
         #1;
         exp_chips.delete();
         @(negedge clk_100);
         check("rst_tx_active", 32'(tx_active), 32'd0);
         check("rst_dds_phase", 32'(dds_phase), 32'd0);
         check("rst_s_ready", 32'(s_if.s_ready), 32'd1);
         check("rst_chip_out", 32'(chip_out), 32'd0);
         rst = 1'b0;
      end else begin
         w = 0;
         while (tx_active && w < WAIT_LIM) begin
            @(negedge clk_100);
            w++;
         end
         check("frame_end_timeout", 32'(tx_active), 32'd0);
      end
      repeat (3) @(negedge clk_100);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      build_pn();
      rst          = 1'b1;
      s_if.s_valid = 1'b0;
      s_if.s_data  = 8'h00;
      s_if.s_last  = 1'b0;
      repeat (3) @(negedge clk_100);
      check("reset_tx_active", 32'(tx_active), 32'd0);
      check("reset_dds_phase", 32'(dds_phase), 32'd0);
      check("reset_chip_out", 32'(chip_out), 32'd0);
      check("reset_strobes", {30'd0, chip_stb, bit_stb}, 32'd0);
      check("reset_underrun", 32'(err_underrun), 32'd0);
      check("reset_s_ready", 32'(s_if.s_ready), 32'd1);
      rst = 1'b0;
      repeat (20) @(negedge clk_100);
      check("idle_tx_active", 32'(tx_active), 32'd0);
      check("idle_s_ready", 32'(s_if.s_ready), 32'd1);

      send_frame(8'hA5, 8'h00, 1, 1'b0, 1'b0);
      send_frame(8'h3C, 8'hF0, 2, 1'b0, 1'b0);
      send_frame(8'h5A, 8'h00, 1, 1'b1, 1'b0);
      send_frame(8'hFF, 8'h00, 1, 1'b0, 1'b0);
      send_frame(8'h81, 8'h00, 1, 1'b0, 1'b1);
      send_frame(8'h42, 8'h00, 1, 1'b0, 1'b0);

      repeat (5) @(negedge clk_100);
      check("chips_drained", 32'(exp_chips.size()), 32'd0);
      check("frames_drained", 32'(exp_frames.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
